// File: rtl/preif_fetch_pc_unit_if.sv
// ---------------------------------------------------------------------------
// preif_fetch_pc_unit_if
//
// Purpose:
//   Bundles the redirect/BPU request inputs and the fetch-group outputs of
//   the pre-IF fetch-PC unit. Clock and reset stay plain module ports.
//
// Signals:
//   preif_wr          stage advance enable (0 = stall)
//   redir_valid       per-source redirect request, index 0 = highest priority
//   redir_target      per-source target, source i at [i*ADDR_W +: ADDR_W]
//   bpu_valid         predicted-taken for the current group
//   bpu_target        predicted target
//   preif_pc          current fetch PC
//   preif_valid_mask  valid words in the fetch group (bit k = word k)
//   preif_adel        current PC misaligned
//   req_valid         fetch request valid towards ITLB/Icache
//   redirect_pending  a latched redirect is waiting
//
// Modports:
//   master  the side that issues redirects and consumes the fetch group
//   slave   the fetch-PC unit itself
// ---------------------------------------------------------------------------
interface preif_fetch_pc_unit_if #(
    parameter int FETCH_WORDS = 2,
    parameter int NUM_REDIR   = 4,
    parameter int ADDR_W      = 32
);
    logic                          preif_wr;
    logic [NUM_REDIR-1:0]          redir_valid;
    logic [NUM_REDIR*ADDR_W-1:0]   redir_target;
    logic                          bpu_valid;
    logic [ADDR_W-1:0]             bpu_target;
    logic [ADDR_W-1:0]             preif_pc;
    logic [FETCH_WORDS-1:0]        preif_valid_mask;
    logic                          preif_adel;
    logic                          req_valid;
    logic                          redirect_pending;

    modport master (
        output preif_wr, redir_valid, redir_target, bpu_valid, bpu_target,
        input  preif_pc, preif_valid_mask, preif_adel, req_valid, redirect_pending
    );

    modport slave (
        input  preif_wr, redir_valid, redir_target, bpu_valid, bpu_target,
        output preif_pc, preif_valid_mask, preif_adel, req_valid, redirect_pending
    );
endinterface

// File: rtl/preif_fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// preif_fetch_pc_unit
//
// Purpose:
//   Holds the fetch PC and produces an aligned fetch group of FETCH_WORDS
//   instructions per cycle. Arbitrates NUM_REDIR prioritised redirect
//   sources plus a BPU target. Redirects arriving during a stall are held
//   in a single pending slot (highest priority wins) and applied on the
//   next advance, so a stall never drops a redirect.
//
// Ports:
//   clk     clock
//   resetn  asynchronous active-low reset
//   bus     preif_fetch_pc_unit_if.slave (requests in, fetch group out)
//
// Configuration macro:
//   PREIF_BPU_EN  when defined, bpu_valid/bpu_target take part in next-PC
//                 selection; when undefined they are ignored.
// ---------------------------------------------------------------------------
module preif_fetch_pc_unit #(
    parameter int              FETCH_WORDS = 2,
    parameter int              NUM_REDIR   = 4,
    parameter logic [31:0]     RESET_PC    = 32'hBFC0_0000,
    parameter int              ADDR_W      = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    preif_fetch_pc_unit_if.slave   bus
);

    localparam int IDX_W = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1;

    logic [ADDR_W-1:0]      pc;
    logic                   pend_valid;
    logic [IDX_W-1:0]       pend_idx;
    logic [ADDR_W-1:0]      pend_target;

    logic                   adel;
    logic [ADDR_W-1:0]      word_off;
    logic [ADDR_W-1:0]      seq_pc;
    logic [FETCH_WORDS-1:0] valid_mask;

    logic                   live_valid;
    logic [IDX_W-1:0]       live_idx;
    logic [ADDR_W-1:0]      live_target;
    logic                   live_beats_pend;
    logic                   live_captures;
    logic                   bpu_take;
    logic [ADDR_W-1:0]      next_pc;

    // Word offset within the group. Masking the shifted PC keeps this valid
    // for FETCH_WORDS=1, where there are no offset bits at all.
    assign adel     = (pc[1:0] != 2'b00);
    assign word_off = (pc >> 2) & ADDR_W'(FETCH_WORDS - 1);

    // A misaligned PC holds in place until a redirect replaces it.
    assign seq_pc   = adel ? pc : pc + ((ADDR_W'(FETCH_WORDS) - word_off) << 2);

    always_comb begin
        for (int k = 0; k < FETCH_WORDS; k++) begin
            valid_mask[k] = !adel && (ADDR_W'(k) >= word_off);
        end
    end

    // Scan from the lowest priority upwards so the lowest set index wins.
    always_comb begin
        live_valid  = 1'b0;
        live_idx    = '0;
        live_target = '0;
        for (int i = NUM_REDIR - 1; i >= 0; i--) begin
            if (bus.redir_valid[i]) begin
                live_valid  = 1'b1;
                live_idx    = IDX_W'(i);
                live_target = bus.redir_target[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // On advance a tie goes to the live request (it is the newer one);
    // during a stall only a strictly higher-priority request replaces pending.
    assign live_beats_pend = live_valid && (!pend_valid || (live_idx <= pend_idx));
    assign live_captures   = live_valid && (!pend_valid || (live_idx <  pend_idx));

`ifdef PREIF_BPU_EN
    assign bpu_take = bus.bpu_valid;
`else
    logic unused_bpu;
    assign bpu_take   = 1'b0;
    assign unused_bpu = ^{bus.bpu_valid, bus.bpu_target};
`endif

    always_comb begin
        next_pc = seq_pc;
        if (live_beats_pend) begin
            next_pc = live_target;
        end else if (pend_valid) begin
            next_pc = pend_target;
        end else if (bpu_take) begin
            next_pc = bus.bpu_target;
        end
    end

    // PC and pending slot. BPU predictions are never latched during a stall.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc          <= RESET_PC[ADDR_W-1:0];
            pend_valid  <= 1'b0;
            pend_idx    <= '0;
            pend_target <= '0;
        end else if (bus.preif_wr) begin
            pc          <= next_pc;
            pend_valid  <= 1'b0;
        end else if (live_captures) begin
            pend_valid  <= 1'b1;
            pend_idx    <= live_idx;
            pend_target <= live_target;
        end
    end

    assign bus.preif_pc         = pc;
    assign bus.preif_valid_mask = valid_mask;
    assign bus.preif_adel       = adel;
    assign bus.req_valid        = !adel;
    assign bus.redirect_pending = pend_valid;

endmodule

// File: tb/tb_preif_fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_preif_fetch_pc_unit
//
// Purpose:
//   Directed, self-checking bench for preif_fetch_pc_unit with the default
//   parameters (FETCH_WORDS=2, NUM_REDIR=4, ADDR_W=32). Expected values are
//   hand-computed; BPU expectations follow PREIF_BPU_EN.
// ---------------------------------------------------------------------------
module tb_preif_fetch_pc_unit;

    localparam int FW = 2;
    localparam int NR = 4;
    localparam int AW = 32;

`ifdef PREIF_BPU_EN
    localparam bit BPU_ON = 1'b1;
`else
    localparam bit BPU_ON = 1'b0;
`endif

    logic clk;
    logic resetn;
    int   check_cnt;
    int   pass_cnt;

    preif_fetch_pc_unit_if #(.FETCH_WORDS(FW), .NUM_REDIR(NR), .ADDR_W(AW)) bus ();

    preif_fetch_pc_unit #(
        .FETCH_WORDS (FW),
        .NUM_REDIR   (NR),
        .RESET_PC    (32'hBFC0_0000),
        .ADDR_W      (AW)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_cnt++;
        if (observed === expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Build a redirect target vector with one source filled in.
    function automatic logic [NR*AW-1:0] oneRedir(input int idx, input logic [AW-1:0] addr);
        logic [NR*AW-1:0] v;
        v = '0;
        v[idx*AW +: AW] = addr;
        return v;
    endfunction

    // Drive inputs, take one clock edge, and settle 1 time unit after it.
    task automatic applyStimulus(input logic wr, input logic [NR-1:0] rv,
                                 input logic [NR*AW-1:0] rt, input logic bv,
                                 input logic [AW-1:0] bt);
        bus.preif_wr     = wr;
        bus.redir_valid  = rv;
        bus.redir_target = rt;
        bus.bpu_valid    = bv;
        bus.bpu_target   = bt;
        @(posedge clk);
        #1;
    endtask

    // Single-source redirect convenience wrapper.
    task automatic stepRedir(input logic wr, input int idx, input logic [AW-1:0] addr);
        logic [NR-1:0] rv;
        rv = '0;
        rv[idx] = 1'b1;
        applyStimulus(wr, rv, oneRedir(idx, addr), 1'b0, '0);
    endtask

    task automatic stepIdle(input logic wr);
        applyStimulus(wr, '0, '0, 1'b0, '0);
    endtask

    initial begin
        logic [31:0] bpu_exp;
        check_cnt = 0;
        pass_cnt  = 0;

        bus.preif_wr     = 1'b0;
        bus.redir_valid  = '0;
        bus.redir_target = '0;
        bus.bpu_valid    = 1'b0;
        bus.bpu_target   = '0;
        resetn           = 1'b0;
        #12;
        resetn = 1'b1;

        // Reset state
        checkOutput("rst_pc",      bus.preif_pc,                 32'hBFC0_0000);
        checkOutput("rst_pending", {31'd0, bus.redirect_pending}, 32'd0);
        checkOutput("rst_mask",    {30'd0, bus.preif_valid_mask}, 32'd3);
        checkOutput("rst_req",     {31'd0, bus.req_valid},        32'd1);
        checkOutput("rst_adel",    {31'd0, bus.preif_adel},       32'd0);

        // Sequential advance
        stepIdle(1'b1);
        checkOutput("seq_pc1", bus.preif_pc, 32'hBFC0_0008);
        stepIdle(1'b1);
        checkOutput("seq_pc2", bus.preif_pc, 32'hBFC0_0010);
        checkOutput("seq_mask", {30'd0, bus.preif_valid_mask}, 32'd3);

        // Redirect into the middle of a group
        stepRedir(1'b1, 3, 32'h8000_1004);
        checkOutput("mid_pc",   bus.preif_pc, 32'h8000_1004);
        checkOutput("mid_mask", {30'd0, bus.preif_valid_mask}, 32'd2);
        stepIdle(1'b1);
        checkOutput("mid_next", bus.preif_pc, 32'h8000_1008);

        // Stall capture, discard of lower priority, replacement by higher
        stepRedir(1'b0, 2, 32'h8000_2000);
        checkOutput("cap_hold",    bus.preif_pc, 32'h8000_1008);
        checkOutput("cap_pending", {31'd0, bus.redirect_pending}, 32'd1);
        checkOutput("stall_req",   {31'd0, bus.req_valid},        32'd1);
        stepRedir(1'b0, 3, 32'h9000_0000);
        stepRedir(1'b0, 1, 32'h8000_3000);
        stepIdle(1'b1);
        checkOutput("rel_pc",      bus.preif_pc, 32'h8000_3000);
        checkOutput("rel_pending", {31'd0, bus.redirect_pending}, 32'd0);

        // Live src0 beats pending src1 on the release edge
        stepRedir(1'b0, 1, 32'h8000_3000);
        stepRedir(1'b1, 0, 32'hBFC0_0380);
        checkOutput("live_win_pc", bus.preif_pc, 32'hBFC0_0380);
        checkOutput("live_win_pend", {31'd0, bus.redirect_pending}, 32'd0);
        stepIdle(1'b1);
        checkOutput("live_win_next", bus.preif_pc, 32'hBFC0_0388);

        // Lower priority during stall is discarded, not substituted
        stepRedir(1'b0, 2, 32'h8000_2000);
        stepRedir(1'b0, 3, 32'h9000_0000);
        stepIdle(1'b1);
        checkOutput("discard_pc", bus.preif_pc, 32'h8000_2000);

        // Equal priority on release: live request wins the tie
        stepRedir(1'b0, 1, 32'h8000_3000);
        stepRedir(1'b1, 1, 32'h8000_6000);
        checkOutput("tie_pc", bus.preif_pc, 32'h8000_6000);

        // Misaligned target holds the PC until a redirect recovers it
        stepRedir(1'b1, 2, 32'h8000_0002);
        checkOutput("adel_pc",   bus.preif_pc, 32'h8000_0002);
        checkOutput("adel_flag", {31'd0, bus.preif_adel},       32'd1);
        checkOutput("adel_mask", {30'd0, bus.preif_valid_mask}, 32'd0);
        checkOutput("adel_req",  {31'd0, bus.req_valid},        32'd0);
        stepIdle(1'b1);
        stepIdle(1'b1);
        checkOutput("adel_hold", bus.preif_pc, 32'h8000_0002);
        stepRedir(1'b1, 1, 32'h8000_0180);
        checkOutput("recov_pc",   bus.preif_pc, 32'h8000_0180);
        checkOutput("recov_adel", {31'd0, bus.preif_adel},       32'd0);
        checkOutput("recov_mask", {30'd0, bus.preif_valid_mask}, 32'd3);

        // BPU target, redirect over BPU, BPU ignored during stall
        bpu_exp = BPU_ON ? 32'h8000_4000 : 32'h8000_0188;
        applyStimulus(1'b1, '0, '0, 1'b1, 32'h8000_4000);
        checkOutput("bpu_pc", bus.preif_pc, bpu_exp);
        applyStimulus(1'b1, 4'b1000, oneRedir(3, 32'h8000_7000), 1'b1, 32'h8000_4000);
        checkOutput("bpu_vs_redir", bus.preif_pc, 32'h8000_7000);
        applyStimulus(1'b0, '0, '0, 1'b1, 32'h8000_4000);
        checkOutput("bpu_stall_pc",   bus.preif_pc, 32'h8000_7000);
        checkOutput("bpu_stall_pend", {31'd0, bus.redirect_pending}, 32'd0);
        stepIdle(1'b1);
        checkOutput("bpu_not_latched", bus.preif_pc, 32'h8000_7008);

        // Wrap-around at the top of the address space
        stepRedir(1'b1, 0, 32'hFFFF_FFF8);
        checkOutput("wrap_top", bus.preif_pc, 32'hFFFF_FFF8);
        stepIdle(1'b1);
        checkOutput("wrap_pc", bus.preif_pc, 32'h0000_0000);

        // Asynchronous reset mid-operation clears pending immediately
        stepRedir(1'b0, 2, 32'h8000_2000);
        checkOutput("pre_rst_pend", {31'd0, bus.redirect_pending}, 32'd1);
        resetn = 1'b0;
        #2;
        checkOutput("async_rst_pc",   bus.preif_pc, 32'hBFC0_0000);
        checkOutput("async_rst_pend", {31'd0, bus.redirect_pending}, 32'd0);
        resetn = 1'b1;
        stepIdle(1'b1);
        checkOutput("post_rst_pc", bus.preif_pc, 32'hBFC0_0008);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
